imem_port_arbiter: RTL and testbench
====================================

Name: imem_port_arbiter

Overview:
- Shares the single-port instruction memory between the fetch stage (port F) and a loader/debug port (port L).
- Fetch has priority. A starvation counter guarantees the loader forward progress, and a lock mode gives the loader exclusive access, e.g. for program download while the core is held.
- The memory read latency is one cycle. `mem_en` is asserted only on a granted access, which saves power.
- Sits between fetch-stage PC logic and the instruction memory.

Parameters:
- `AW`, 32, address width.
- `DW`, 32, data width.
- `STARVE_LIMIT`, 4, consecutive cycles L may lose to F before L is forced through; legal range 1..(2^CNT_W - 1).
- `CNT_W`, 3, starvation counter width.

Ports:
- `clk` in 1: clock, all state updates on the rising edge.
- `reset` in 1: synchronous, active-low reset (asserted when 0 at a rising edge of `clk`).
- `f_req` in 1: fetch read request.
- `f_addr` in AW: fetch address.
- `f_flush` in 1: redirect; kills the response to a grant made this cycle.
- `f_gnt` out 1: fetch request accepted this cycle (combinational).
- `f_rvalid` out 1: fetch data valid (one cycle after `f_gnt`).
- `f_rdata` out DW: fetch data.
- `fetch_stall` out 1: equals `f_req && !f_gnt`.
- `l_req` in 1: loader request.
- `l_we` in 1: loader write (1) or read (0).
- `l_addr` in AW: loader address.
- `l_wdata` in DW: loader write data.
- `l_lock` in 1: request exclusive memory ownership.
- `l_gnt` out 1: loader request accepted this cycle (combinational).
- `l_rvalid` out 1: loader response (read data or write ack), one cycle after `l_gnt`.
- `l_rdata` out DW: loader read data; don't-care on write ack.
- `locked` out 1: arbiter is in LOCKED state.
- `mem_en` out 1: memory access enable.
- `mem_we` out 1: memory write enable.
- `mem_addr` out AW: memory address.
- `mem_wdata` out DW: memory write data.
- `mem_rdata` in DW: memory read data, valid the cycle after `mem_en`.

Behaviour:
- **Reset** (`reset`==0 at a clock edge):
  - state=RUN, starve_cnt=0, response tag=NONE.
  - `f_rvalid`=`l_rvalid`=`locked`=0.
  - `mem_en`/`mem_we`=0 while in reset.
  - Reset mid-access drops the pending response (no `rvalid` the following cycle).
- **State RUN**, combinational grant:
  - Only `f_req` -> F granted.
  - Only `l_req` -> L granted.
  - Both, with starve_cnt < STARVE_LIMIT -> F granted, starve_cnt++.
  - Both, with starve_cnt == STARVE_LIMIT -> L granted.
  - starve_cnt clears to 0 on any L grant or any cycle with `l_req`=0.
- **State LOCKED**:
  - `f_gnt`=0 always.
  - L granted whenever `l_req`; starve_cnt held at 0.
- **Transitions**:
  - RUN -> LOCKED at the edge where `l_lock`=1; grants in that cycle still follow RUN rules.
  - LOCKED -> RUN at the edge where `l_lock`=0.
  - `locked` = (state==LOCKED).
- **Memory drive**:
  - Granted port drives `mem_addr`, and for L also `mem_we`=`l_we` and `mem_wdata`.
  - `mem_en`=1 only on a grant.
  - No grant -> `mem_en`=0, `mem_we`=0, `mem_addr`/`mem_wdata` hold previous values (no toggling).
- **Response**:
  - A registered tag {NONE, F, L} records the grant.
  - Next cycle: tag F -> `f_rvalid`=1, `f_rdata`=`mem_rdata`. Tag L -> `l_rvalid`=1, `l_rdata`=`mem_rdata`.
  - Exactly one `rvalid` per grant, except when killed by `f_flush`.
  - Outstanding depth is 1; back-to-back grants every cycle are legal.
- **Flush**: `f_flush`=1 in a cycle with `f_gnt`=1 -> tag becomes NONE and no `f_rvalid` next cycle. `f_flush` has no effect on L.
- **Requester rules**: `f_addr`/`l_*` must be held stable while `req`=1 and `gnt`=0. A request may be withdrawn before grant.
- **Ordering**: a loader write granted in cycle N is visible to any fetch granted in cycle N+1 or later.

Optional Feature:
- Macro `IMEM_FETCH_REUSE_EN`.
- **Defined**: a one-entry fetch buffer {valid, addr, data} is captured on every delivered F response.
  - F grant with buf.valid && `f_addr`==buf.addr -> `mem_en`=0; `f_rvalid` next cycle with `f_rdata`=buf.data.
  - Invalidated by reset, by any granted loader write, and by entering LOCKED.
- **Undefined**: every grant asserts `mem_en`; no buffer logic is present.

Test Plan:
- Reset with `reset`=0 for 2 cycles while `f_req`=`l_req`=1 -> all outputs 0. After release, `f_req`=1, `f_addr`=0x0 -> `f_gnt`=1, `mem_en`=1, `mem_addr`=0x0. Next cycle `f_rvalid`=1, `f_rdata`=`mem_rdata`=0x00000013.
- Starvation: `f_req`=1 every cycle with incrementing addresses; `l_req`=1, `l_we`=0, `l_addr`=0x100. Checks, with STARVE_LIMIT=4:
  - F granted cycles 0-3; L granted cycle 4 with `fetch_stall`=1 that cycle.
  - `l_rvalid` cycle 5.
  - starve_cnt back to 0.
- Lock and write: `l_lock`=1, then writes 0xDEADBEEF@0x40 and 0x12345678@0x44 with `f_req`=1. Checks:
  - `locked`=1 from the next cycle; `f_gnt`=0 and `fetch_stall`=1 throughout.
  - Each write gives `mem_we`=1 and a one-cycle-later `l_rvalid`.
  - After `l_lock`=0, fetch 0x40 returns 0xDEADBEEF.
- Flush: F granted at 0x8 with `f_flush`=1 in the same cycle -> no `f_rvalid` next cycle. Unflushed F grant at 0xC the following cycle -> `f_rvalid` as normal.
- Idle power: `f_req`=`l_req`=0 for 10 cycles -> `mem_en`=0 and `mem_addr` unchanged all 10 cycles.
- `IMEM_FETCH_REUSE_EN` defined:
  - Fetch 0x20 twice -> second grant has `mem_en`=0 and the same `f_rdata`.
  - Loader write to 0x20, then fetch 0x20 -> `mem_en`=1 and the new data is returned.

Source files
------------

// File: rtl/imem_port_arbiter.sv
// Purpose : shares a single-port instruction memory between fetch (F) and a loader/debug port (L).
// Latency : grants are combinational; read data / write ack return exactly one cycle after the grant.
// Backpres: a requester holds its request stable until granted; F has priority, L is forced after STARVE_LIMIT losses.
//
// Ports:
//   clk, reset         - clock, synchronous active-low reset
//   f_req/f_addr       - fetch read request; f_flush kills the response of a grant made this cycle
//   f_gnt/fetch_stall  - fetch accepted / fetch requested but not accepted (combinational)
//   f_rvalid/f_rdata   - fetch response, one cycle after f_gnt
//   l_req/l_we/l_addr/l_wdata/l_lock - loader request; l_lock asks for exclusive ownership
//   l_gnt, l_rvalid/l_rdata, locked  - loader accepted, loader response, LOCKED state flag
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata - single-port memory, 1-cycle read latency
//
// Optional build macro IMEM_FETCH_REUSE_EN adds a one-entry fetch buffer that serves a
// repeated fetch of the last delivered address without enabling the memory.

module imem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic          clk,
  input  logic          reset,
  // fetch port
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  input  logic          f_flush,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic [DW-1:0] f_rdata,
  output logic          fetch_stall,
  // loader port
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  input  logic          l_lock,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [DW-1:0] l_rdata,
  output logic          locked,
  // memory
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic {
    ST_RUN,
    ST_LOCKED
  } state_t;

  // Which port owns the data returning from the memory this cycle.
  // TAG_FBUF means the fetch is answered from the reuse buffer instead.
  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_F,
    TAG_L,
    TAG_FBUF
  } tag_t;

  state_t           state;
  tag_t             tag;
  tag_t             tag_nxt;
  logic [CNT_W-1:0] starve_cnt;
  logic             starved;
  logic [AW-1:0]    addr_q;
  logic [DW-1:0]    wdata_q;
  logic             f_hit;
  logic [DW-1:0]    fbuf_data;

  assign starved = (starve_cnt == LIMIT);

  // ---------------------------------------------------------------------------
  // Grant logic. Everything is gated while reset is asserted so the memory
  // sees no access and no response can be scheduled.
  // ---------------------------------------------------------------------------
  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (reset) begin
      if (state == ST_LOCKED) begin
        l_gnt = l_req;
      end else begin
        f_gnt = f_req && !(l_req && starved);
        l_gnt = l_req && !f_gnt;
      end
    end
  end

  // Stall is meaningless during reset; keep it low there like every other output.
  assign fetch_stall = reset && f_req && !f_gnt;
  assign locked      = (state == ST_LOCKED);

  // ---------------------------------------------------------------------------
  // Optional fetch reuse buffer
  // ---------------------------------------------------------------------------
`ifdef IMEM_FETCH_REUSE_EN
  logic          buf_vld;
  logic [AW-1:0] buf_addr;
  logic [DW-1:0] buf_data;
  logic [AW-1:0] f_addr_q;

  assign f_hit     = f_gnt && buf_vld && (f_addr == buf_addr);
  assign fbuf_data = buf_data;

  always_ff @(posedge clk) begin
    if (!reset) begin
      buf_vld  <= 1'b0;
      buf_addr <= '0;
      buf_data <= '0;
      f_addr_q <= '0;
    end else begin
      if (f_gnt) begin
        f_addr_q <= f_addr;
      end
      // Invalidation beats capture: a response delivered in the same cycle as
      // a loader write may carry the pre-write contents of that address.
      if ((l_gnt && l_we) || (state == ST_RUN && l_lock)) begin
        buf_vld <= 1'b0;
      end else if (tag == TAG_F) begin
        buf_vld  <= 1'b1;
        buf_addr <= f_addr_q;
        buf_data <= mem_rdata;
      end
    end
  end
`else
  assign f_hit     = 1'b0;
  assign fbuf_data = '0;
`endif

  // ---------------------------------------------------------------------------
  // Memory drive. With no access the address/data buses keep their last value
  // so idle cycles do not toggle the memory inputs.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if (f_gnt && !f_hit) begin
      mem_en   = 1'b1;
      mem_addr = f_addr;
    end else if (l_gnt) begin
      mem_en    = 1'b1;
      mem_we    = l_we;
      mem_addr  = l_addr;
      mem_wdata = l_wdata;
    end
  end

  // Response tag for next cycle; a flushed fetch schedules nothing.
  always_comb begin
    tag_nxt = TAG_NONE;
    if (f_gnt && !f_flush) begin
      tag_nxt = f_hit ? TAG_FBUF : TAG_F;
    end else if (l_gnt) begin
      tag_nxt = TAG_L;
    end
  end

  // ---------------------------------------------------------------------------
  // State, starvation counter, response tag and held memory buses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_RUN;
      starve_cnt <= '0;
      tag        <= TAG_NONE;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state <= l_lock ? ST_LOCKED : ST_RUN;
      // Counts only cycles where L asked and lost; any L grant or idle L clears it.
      // In LOCKED every L request is granted, so the counter stays at zero.
      if (l_req && !l_gnt) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end else begin
        starve_cnt <= '0;
      end
      tag     <= tag_nxt;
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Responses. Data is forced to zero when not valid to keep the buses quiet.
  // ---------------------------------------------------------------------------
  assign f_rvalid = (tag == TAG_F) || (tag == TAG_FBUF);
  assign l_rvalid = (tag == TAG_L);

  always_comb begin
    f_rdata = '0;
    if (tag == TAG_F) begin
      f_rdata = mem_rdata;
    end else if (tag == TAG_FBUF) begin
      f_rdata = fbuf_data;
    end
  end

  assign l_rdata = l_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Self-checking bench for imem_port_arbiter: behavioural single-port memory,
// reference memory image, and a response scoreboard.
// Responses expected by the stimulus are queued with their due cycle and
// retired by a monitor when the DUT raises f_rvalid or l_rvalid.

module tb_imem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          f_req, f_flush, f_gnt, f_rvalid, fetch_stall;
  logic [AW-1:0] f_addr;
  logic [DW-1:0] f_rdata;
  logic          l_req, l_we, l_lock, l_gnt, l_rvalid, locked;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata, l_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  imem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_flush(f_flush), .f_gnt(f_gnt),
    .f_rvalid(f_rvalid), .f_rdata(f_rdata), .fetch_stall(fetch_stall),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_lock(l_lock),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata), .locked(locked),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    return (i == 0) ? 32'h0000_0013 : (32'hA500_0000 | 32'(i));
  endfunction

  // Behavioural memory, loaded while the design is in reset.
  logic [DW-1:0] mem [0:255];
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      mem_rdata <= '0;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[9:2]];
    end
  end

  // Reference image kept by the stimulus side.
  logic [DW-1:0] ref_mem [0:255];
  function automatic int idx(input logic [31:0] a);
    return int'(a[9:2]);
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    bit          is_l;
    bit          chk;
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic push_exp(input bit is_l, input bit chk, input logic [31:0] d);
    exp_t e;
    e.due  = cyc + 1;
    e.is_l = is_l;
    e.chk  = chk;
    e.data = d;
    sb_q.push_back(e);
  endtask

  task automatic idle_inputs();
    f_req = 0; f_flush = 0; l_req = 0; l_we = 0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 0; f_req = 1; l_req = 1; f_addr = 32'h4; l_addr = 32'h100;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      tests_run++;
      if ({f_gnt, l_gnt, f_rvalid, l_rvalid, fetch_stall, locked, mem_en, mem_we} !== 8'b0) begin
        tests_failed++;
        $display("FAIL reset_ctrl: got %b want 00000000",
                 {f_gnt, l_gnt, f_rvalid, l_rvalid, fetch_stall, locked, mem_en, mem_we});
      end
      tests_run++;
      if (mem_addr !== 0 || f_rdata !== 0 || l_rdata !== 0) begin
        tests_failed++;
        $display("FAIL reset_bus: mem_addr=%h f_rdata=%h l_rdata=%h want 0", mem_addr, f_rdata, l_rdata);
      end
    end
    @(negedge clk); reset = 1; l_req = 0; f_addr = 32'h0; #1;
    tests_run++;
    if (f_gnt !== 1 || mem_en !== 1 || mem_addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL first_fetch: f_gnt=%b mem_en=%b mem_addr=%h want 1 1 0", f_gnt, mem_en, mem_addr);
    end
    push_exp(0, 1, ref_mem[0]);
    @(negedge clk); idle_inputs(); #1;
    tests_run++;
    if (f_rvalid !== 1 || f_rdata !== 32'h0000_0013) begin
      tests_failed++;
      $display("FAIL first_resp: f_rvalid=%b f_rdata=%h want 1 00000013", f_rvalid, f_rdata);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_starvation();
    logic [31:0] fa;
    logic        exp_f;
    fa = 32'h200;
    l_we = 0; l_addr = 32'h100;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 5; i++) begin
        @(negedge clk); f_req = 1; l_req = 1; f_addr = fa; #1;
        exp_f = (i < 4);
        tests_run++;
        if (f_gnt !== exp_f || l_gnt !== !exp_f || fetch_stall !== !exp_f ||
            mem_addr !== (exp_f ? fa : 32'h100)) begin
          tests_failed++;
          $display("FAIL starve r%0d c%0d: f_gnt=%b l_gnt=%b stall=%b addr=%h want %b %b %b %h",
                   r, i, f_gnt, l_gnt, fetch_stall, mem_addr, exp_f, !exp_f, !exp_f,
                   exp_f ? fa : 32'h100);
        end
        if (r == 1 && i == 0) begin
          tests_run++;
          if (l_rvalid !== 1 || l_rdata !== ref_mem[idx(32'h100)]) begin
            tests_failed++;
            $display("FAIL starve_lresp: l_rvalid=%b l_rdata=%h want 1 %h",
                     l_rvalid, l_rdata, ref_mem[idx(32'h100)]);
          end
        end
        if (exp_f) begin
          push_exp(0, 1, ref_mem[idx(fa)]);
          fa = fa + 4;
        end else begin
          push_exp(1, 1, ref_mem[idx(32'h100)]);
        end
      end
    end
    @(negedge clk); idle_inputs(); #1;
    tests_run++;
    if (l_rvalid !== 1) begin
      tests_failed++;
      $display("FAIL starve_lresp2: l_rvalid=%b want 1", l_rvalid);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_lock_write();
    @(negedge clk); l_lock = 1; f_req = 1; f_addr = 32'h300; l_req = 0; #1;
    tests_run++;
    if (f_gnt !== 1 || locked !== 0) begin
      tests_failed++;
      $display("FAIL lock_entry: f_gnt=%b locked=%b want 1 0", f_gnt, locked);
    end
    push_exp(0, 1, ref_mem[idx(32'h300)]);
    for (int w = 0; w < 2; w++) begin
      @(negedge clk);
      l_req = 1; l_we = 1;
      l_addr  = (w == 0) ? 32'h40 : 32'h44;
      l_wdata = (w == 0) ? 32'hDEADBEEF : 32'h12345678;
      #1;
      tests_run++;
      if (locked !== 1 || f_gnt !== 0 || fetch_stall !== 1 || l_gnt !== 1 || mem_en !== 1 ||
          mem_we !== 1 || mem_addr !== l_addr || mem_wdata !== l_wdata) begin
        tests_failed++;
        $display("FAIL lock_write%0d: locked=%b f_gnt=%b stall=%b l_gnt=%b en=%b we=%b addr=%h wd=%h want 1 0 1 1 1 1 %h %h",
                 w, locked, f_gnt, fetch_stall, l_gnt, mem_en, mem_we, mem_addr, mem_wdata, l_addr, l_wdata);
      end
      if (w == 1) begin
        tests_run++;
        if (l_rvalid !== 1) begin
          tests_failed++;
          $display("FAIL lock_ack0: l_rvalid=%b want 1", l_rvalid);
        end
      end
      ref_mem[idx(l_addr)] = l_wdata;
      push_exp(1, 0, 32'h0);
    end
    @(negedge clk); l_req = 0; l_we = 0; l_lock = 0; #1;
    tests_run++;
    if (locked !== 1 || f_gnt !== 0 || fetch_stall !== 1 || mem_en !== 0 || l_rvalid !== 1) begin
      tests_failed++;
      $display("FAIL lock_exit: locked=%b f_gnt=%b stall=%b en=%b l_rvalid=%b want 1 0 1 0 1",
               locked, f_gnt, fetch_stall, mem_en, l_rvalid);
    end
    @(negedge clk); f_addr = 32'h40; #1;
    tests_run++;
    if (locked !== 0 || f_gnt !== 1) begin
      tests_failed++;
      $display("FAIL unlock_fetch: locked=%b f_gnt=%b want 0 1", locked, f_gnt);
    end
    push_exp(0, 1, ref_mem[idx(32'h40)]);
    @(negedge clk); f_addr = 32'h44; #1;
    tests_run++;
    if (f_gnt !== 1 || f_rvalid !== 1 || f_rdata !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL readback40: f_gnt=%b f_rvalid=%b f_rdata=%h want 1 1 deadbeef", f_gnt, f_rvalid, f_rdata);
    end
    push_exp(0, 1, ref_mem[idx(32'h44)]);
    @(negedge clk); idle_inputs(); #1;
    tests_run++;
    if (f_rvalid !== 1 || f_rdata !== 32'h12345678) begin
      tests_failed++;
      $display("FAIL readback44: f_rvalid=%b f_rdata=%h want 1 12345678", f_rvalid, f_rdata);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_flush();
    @(negedge clk); f_req = 1; f_addr = 32'h8; f_flush = 1; #1;
    tests_run++;
    if (f_gnt !== 1 || mem_en !== 1) begin
      tests_failed++;
      $display("FAIL flush_gnt: f_gnt=%b mem_en=%b want 1 1", f_gnt, mem_en);
    end
    @(negedge clk); f_addr = 32'hC; f_flush = 0; #1;
    tests_run++;
    if (f_gnt !== 1 || f_rvalid !== 0) begin
      tests_failed++;
      $display("FAIL flush_kill: f_gnt=%b f_rvalid=%b want 1 0", f_gnt, f_rvalid);
    end
    push_exp(0, 1, ref_mem[idx(32'hC)]);
    // Flush during a loader access must not disturb it.
    @(negedge clk); f_req = 0; l_req = 1; l_we = 0; l_addr = 32'h100; f_flush = 1; #1;
    tests_run++;
    if (l_gnt !== 1 || f_rvalid !== 1 || f_rdata !== ref_mem[idx(32'hC)]) begin
      tests_failed++;
      $display("FAIL flush_next: l_gnt=%b f_rvalid=%b f_rdata=%h want 1 1 %h",
               l_gnt, f_rvalid, f_rdata, ref_mem[idx(32'hC)]);
    end
    push_exp(1, 1, ref_mem[idx(32'h100)]);
    @(negedge clk); idle_inputs(); #1;
    tests_run++;
    if (l_rvalid !== 1 || l_rdata !== ref_mem[idx(32'h100)]) begin
      tests_failed++;
      $display("FAIL flush_l: l_rvalid=%b l_rdata=%h want 1 %h", l_rvalid, l_rdata, ref_mem[idx(32'h100)]);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_idle();
    @(negedge clk); f_req = 1; f_addr = 32'h3C0; #1;
    tests_run++;
    if (f_gnt !== 1 || mem_addr !== 32'h3C0) begin
      tests_failed++;
      $display("FAIL idle_setup: f_gnt=%b mem_addr=%h want 1 3c0", f_gnt, mem_addr);
    end
    push_exp(0, 1, ref_mem[idx(32'h3C0)]);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); idle_inputs(); #1;
      tests_run++;
      if (mem_en !== 0 || mem_we !== 0 || mem_addr !== 32'h3C0) begin
        tests_failed++;
        $display("FAIL idle_c%0d: mem_en=%b mem_we=%b mem_addr=%h want 0 0 3c0", k, mem_en, mem_we, mem_addr);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reuse();
    logic exp_en_repeat;
`ifdef IMEM_FETCH_REUSE_EN
    exp_en_repeat = 1'b0;
`else
    exp_en_repeat = 1'b1;
`endif
    @(negedge clk); f_req = 1; f_addr = 32'h20; #1;
    tests_run++;
    if (f_gnt !== 1 || mem_en !== 1) begin
      tests_failed++;
      $display("FAIL reuse_first: f_gnt=%b mem_en=%b want 1 1", f_gnt, mem_en);
    end
    push_exp(0, 1, ref_mem[idx(32'h20)]);
    // Loader read in between changes mem_rdata, so a buffered answer is distinguishable.
    @(negedge clk); f_req = 0; l_req = 1; l_we = 0; l_addr = 32'h100; #1;
    push_exp(1, 1, ref_mem[idx(32'h100)]);
    @(negedge clk); l_req = 0; f_req = 1; f_addr = 32'h20; #1;
    tests_run++;
    if (f_gnt !== 1 || mem_en !== exp_en_repeat) begin
      tests_failed++;
      $display("FAIL reuse_repeat: f_gnt=%b mem_en=%b want 1 %b", f_gnt, mem_en, exp_en_repeat);
    end
    push_exp(0, 1, ref_mem[idx(32'h20)]);
    @(negedge clk); f_req = 0; l_req = 1; l_we = 1; l_addr = 32'h20; l_wdata = 32'hCAFEF00D; #1;
    tests_run++;
    if (l_gnt !== 1 || mem_we !== 1 || f_rvalid !== 1 || f_rdata !== ref_mem[idx(32'h20)]) begin
      tests_failed++;
      $display("FAIL reuse_data: l_gnt=%b we=%b f_rvalid=%b f_rdata=%h want 1 1 1 %h",
               l_gnt, mem_we, f_rvalid, f_rdata, ref_mem[idx(32'h20)]);
    end
    ref_mem[idx(32'h20)] = 32'hCAFEF00D;
    push_exp(1, 0, 32'h0);
    @(negedge clk); l_req = 0; l_we = 0; f_req = 1; f_addr = 32'h20; #1;
    tests_run++;
    if (f_gnt !== 1 || mem_en !== 1) begin
      tests_failed++;
      $display("FAIL reuse_inval: f_gnt=%b mem_en=%b want 1 1", f_gnt, mem_en);
    end
    push_exp(0, 1, 32'hCAFEF00D);
    @(negedge clk); idle_inputs(); #1;
    tests_run++;
    if (f_rvalid !== 1 || f_rdata !== 32'hCAFEF00D) begin
      tests_failed++;
      $display("FAIL reuse_new: f_rvalid=%b f_rdata=%h want 1 cafef00d", f_rvalid, f_rdata);
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    reset = 0; f_req = 0; f_flush = 0; f_addr = '0;
    l_req = 0; l_we = 0; l_lock = 0; l_addr = '0; l_wdata = '0;

    // Response monitor: retires scoreboard entries against f_rvalid / l_rvalid.
    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk); #2;
          while (sb_q.size() > 0 && sb_q[0].due < cyc) begin
            tests_run++;
            tests_failed++;
            $display("FAIL sb_missing: no response at cycle %0d, expected %s data %h",
                     sb_q[0].due, sb_q[0].is_l ? "L" : "F", sb_q[0].data);
            void'(sb_q.pop_front());
          end
          if (f_rvalid === 1'b1 || l_rvalid === 1'b1) begin
            tests_run++;
            if (sb_q.size() == 0 || sb_q[0].due != cyc) begin
              tests_failed++;
              $display("FAIL sb_unexpected: f_rvalid=%b l_rvalid=%b at cycle %0d, none expected",
                       f_rvalid, l_rvalid, cyc);
            end else begin
              e = sb_q.pop_front();
              if ((f_rvalid === 1'b1 && l_rvalid === 1'b1) || (l_rvalid !== e.is_l) ||
                  (e.chk && (e.is_l ? l_rdata : f_rdata) !== e.data)) begin
                tests_failed++;
                $display("FAIL sb_resp: f_rvalid=%b l_rvalid=%b f_rdata=%h l_rdata=%h want port %s data %h",
                         f_rvalid, l_rvalid, f_rdata, l_rdata, e.is_l ? "L" : "F", e.data);
              end
            end
          end
        end
      end
    join_none

    test_reset();
    test_starvation();
    test_lock_write();
    test_flush();
    test_idle();
    test_reuse();

    repeat (3) @(negedge clk);
    #3;
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL sb_drain: %0d responses outstanding, want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
